// File: rtl/hazard_ctrl.sv
// Hazard and multi-cycle scheduling controller for the five-stage MIPS core.
// Produces the freeze/bubble controls, the HI/LO busy window and a stall counter.
module hazard_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_tuse_rs,
   input  logic [1:0]  D_tuse_rt,
   input  logic        D_is_md,
   input  logic [4:0]  E_A3,
   input  logic [1:0]  E_tnew,
   input  logic [4:0]  M_A3,
   input  logic [1:0]  M_tnew,
   input  logic        E_md_start,
   input  logic        E_md_div,
   output logic        stall,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_clr,
   output logic        md_busy,
   output logic [31:0] stall_cycles
);

   typedef enum logic {
      MD_IDLE,
      MD_BUSY
   } md_state_t;

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_stall_cycles;

   logic w_stall_rs;
   logic w_stall_rt;
   logic w_stall_md;
   logic w_stall;

   // A source stalls only when its producer's result arrives later than D needs it.
   assign w_stall_rs = (D_rs != 5'd0) &
                       (((D_rs == E_A3) & (D_tuse_rs < E_tnew)) |
                        ((D_rs == M_A3) & (D_tuse_rs < M_tnew)));
   assign w_stall_rt = (D_rt != 5'd0) &
                       (((D_rt == E_A3) & (D_tuse_rt < E_tnew)) |
                        ((D_rt == M_A3) & (D_tuse_rt < M_tnew)));
   // The start term covers the cycle before the busy window opens.
   assign w_stall_md = D_is_md & ((r_state == MD_BUSY) | E_md_start);
   assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

   assign stall        = w_stall;
   assign pc_en        = ~w_stall;
   assign fd_en        = ~w_stall;
   assign de_clr       = w_stall;
   assign md_busy      = (r_state == MD_BUSY);
   assign stall_cycles = r_stall_cycles;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (E_md_start) begin
                  r_cnt   <= E_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                  r_state <= MD_BUSY;
               end
            end
            MD_BUSY: begin
               // A start seen here is illegal and deliberately ignored.
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= MD_IDLE;
               end
            end
            default: begin
               r_state <= MD_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  D_rs, D_rt, E_A3, M_A3;
   logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
   logic        D_is_md, E_md_start, E_md_div;
   logic        stall, pc_en, fd_en, de_clr, md_busy;
   logic [31:0] stall_cycles;

   int n_vec = 0;
   int n_err = 0;

   // Model: the busy window is the set of cycle indices cyc <= busy_end.
   int     cyc      = 0;
   int     busy_end = -1;
   longint m_sc     = 0;

   hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
      .D_is_md(D_is_md), .E_A3(E_A3), .E_tnew(E_tnew), .M_A3(M_A3), .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_div(E_md_div),
      .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
      .md_busy(md_busy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic exp_busy();
      return cyc <= busy_end;
   endfunction

   function automatic logic exp_stall();
      logic hz = 1'b0;
      for (int s = 0; s < 2; s++) begin
         int r = (s == 0) ? int'(D_rs) : int'(D_rt);
         int u = (s == 0) ? int'(D_tuse_rs) : int'(D_tuse_rt);
         if (r != 0) begin
            if (r == int'(E_A3) && int'(E_tnew) > u) hz = 1'b1;
            if (r == int'(M_A3) && int'(M_tnew) > u) hz = 1'b1;
         end
      end
      if (D_is_md && (exp_busy() || E_md_start)) hz = 1'b1;
      return hz;
   endfunction

   // Advance one clock: inputs are held across the posedge, model follows.
   task automatic tick();
      logic s;
      logic b;
      s = exp_stall();
      b = exp_busy();
      @(posedge clk);
      if (reset) begin
         busy_end = cyc;
         m_sc     = 0;
      end else begin
         if (E_md_start && !b) busy_end = cyc + (E_md_div ? DIV_LAT : MULT_LAT);
         if (s) m_sc = (m_sc + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sc + 1;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      D_rs = '0; D_rt = '0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 1'b0;
      E_A3 = '0; E_tnew = '0; M_A3 = '0; M_tnew = '0;
      E_md_start = 1'b0; E_md_div = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      D_tuse_rs = '0; D_tuse_rt = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if ({stall, pc_en, fd_en, de_clr, md_busy} !== 5'b01100) begin
         n_err++;
         $display("FAIL reset_ctrl: got stall/pc/fd/clr/busy=%b want 01100",
                  {stall, pc_en, fd_en, de_clr, md_busy});
      end
      n_vec++;
      if (stall_cycles !== 32'd0) begin
         n_err++;
         $display("FAIL reset_count: got %0d want 0", stall_cycles);
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
      #1;
      n_vec++;
      if ({stall, de_clr, pc_en, fd_en} !== {exp_stall(), exp_stall(), ~exp_stall(), ~exp_stall()}
          || stall !== 1'b1) begin
         n_err++;
         $display("FAIL load_use: got stall/clr/pc/fd=%b want 1100", {stall, de_clr, pc_en, fd_en});
      end
      E_tnew = 2'd1;
      #1;
      n_vec++;
      if (stall !== exp_stall() || stall !== 1'b0) begin
         n_err++;
         $display("FAIL load_use_ready: got stall=%b want 0", stall);
      end
   endtask

   task automatic test_zero_reg();
      clear_inputs();
      D_rs = 5'd0; E_A3 = 5'd0; E_tnew = 2'd2; D_tuse_rs = 2'd0;
      M_A3 = 5'd0; M_tnew = 2'd2; D_rt = 5'd0; D_tuse_rt = 2'd0;
      #1;
      n_vec++;
      if (stall !== exp_stall() || stall !== 1'b0) begin
         n_err++;
         $display("FAIL zero_reg: got stall=%b want 0", stall);
      end
   endtask

   task automatic test_m_hazard();
      clear_inputs();
      M_A3 = 5'd5; M_tnew = 2'd1; D_rt = 5'd5; D_tuse_rt = 2'd0;
      #1;
      n_vec++;
      if (stall !== exp_stall() || stall !== 1'b1) begin
         n_err++;
         $display("FAIL m_hazard: got stall=%b want 1", stall);
      end
      D_tuse_rt = 2'd3;
      #1;
      n_vec++;
      if (stall !== exp_stall() || stall !== 1'b0) begin
         n_err++;
         $display("FAIL m_hazard_unused: got stall=%b want 0", stall);
      end
   endtask

   task automatic test_mult_mflo();
      int n_stall = 0;
      int n_busy  = 0;
      int first_gap = -1;
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      D_is_md = 1'b1;
      E_md_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_vec++;
         if (stall !== exp_stall() || md_busy !== exp_busy()) begin
            n_err++;
            $display("FAIL mult_cycle%0d: got stall=%b busy=%b want stall=%b busy=%b",
                     i, stall, md_busy, exp_stall(), exp_busy());
         end
         if (stall && first_gap < 0) n_stall++;
         else if (!stall && first_gap < 0) first_gap = i;
         if (md_busy) n_busy++;
         tick();
         E_md_start = 1'b0;
      end
      n_vec++;
      if (n_stall !== 6 || n_busy !== MULT_LAT) begin
         n_err++;
         $display("FAIL mult_window: got stall_run=%0d busy=%0d want 6 and %0d",
                  n_stall, n_busy, MULT_LAT);
      end
      n_vec++;
      if (stall_cycles !== 32'd6) begin
         n_err++;
         $display("FAIL mult_count: got %0d want 6", stall_cycles);
      end
   endtask

   task automatic test_div_reset();
      int n_busy = 0;
      clear_inputs();
      D_is_md = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      E_md_start = 1'b1; E_md_div = 1'b1;
      tick();
      E_md_start = 1'b0; E_md_div = 1'b0;
      tick();
      tick();
      tick();
      #1;
      n_vec++;
      if (md_busy !== 1'b1 || md_busy !== exp_busy()) begin
         n_err++;
         $display("FAIL div_busy4: got busy=%b want 1", md_busy);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if (md_busy !== 1'b0 || stall_cycles !== 32'd0) begin
         n_err++;
         $display("FAIL div_reset: got busy=%b count=%0d want 0 and 0", md_busy, stall_cycles);
      end
      D_is_md = 1'b0;
      E_md_start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         E_md_start = 1'b0;
         #1;
         if (md_busy) n_busy++;
      end
      n_vec++;
      if (n_busy !== MULT_LAT) begin
         n_err++;
         $display("FAIL div_then_mult: got busy cycles=%0d want %0d", n_busy, MULT_LAT);
      end
   endtask

   task automatic test_saturation();
      clear_inputs();
      E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
      dut.r_stall_cycles = 32'hFFFF_FFFE;
      m_sc = 64'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         n_vec++;
         if (stall_cycles !== 32'(m_sc) || stall_cycles !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL saturate%0d: got %h want ffffffff", i, stall_cycles);
         end
      end
   endtask

   task automatic test_random();
      clear_inputs();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 39) == 0);
         D_rs       = 5'($urandom_range(0, 3));
         D_rt       = 5'($urandom_range(0, 3));
         D_tuse_rs  = 2'($urandom);
         D_tuse_rt  = 2'($urandom);
         D_is_md    = ($urandom_range(0, 2) == 0);
         E_A3       = 5'($urandom_range(0, 3));
         E_tnew     = 2'($urandom);
         M_A3       = 5'($urandom_range(0, 3));
         M_tnew     = 2'($urandom);
         E_md_start = ($urandom_range(0, 7) == 0);
         E_md_div   = 1'($urandom);
         #1;
         n_vec++;
         if ({stall, pc_en, fd_en, de_clr} !== {exp_stall(), ~exp_stall(), ~exp_stall(), exp_stall()}
             || md_busy !== exp_busy() || stall_cycles !== 32'(m_sc)) begin
            n_err++;
            $display("FAIL random%0d: got stall/pc/fd/clr=%b busy=%b cnt=%0d want stall=%b busy=%b cnt=%0d",
                     i, {stall, pc_en, fd_en, de_clr}, md_busy, stall_cycles,
                     exp_stall(), exp_busy(), m_sc);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_zero_reg();
      test_m_hazard();
      test_mult_mflo();
      test_div_reset();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multi-cycle scheduling controller for the five-stage MIPS core. It decides each cycle whether the F/D stages freeze and a bubble is injected into the D/E register, using two inputs: the operand-use deadlines (Tuse) of the instruction in D, and the result-ready times (Tnew) of instructions in E and M. It also owns the HI/LO multiply/divide busy counter, which serialises MD instructions, and a saturating stall-cycle performance counter.

## Interface
Parameters:
- MULT_LAT, default 5: busy cycles for mult/multu after start.
- DIV_LAT, default 10: busy cycles for div/divu after start.
- CNT_W, default 4: busy counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- D_rs, input, 5: rs field of the instruction in D.
- D_rt, input, 5: rt field of the instruction in D.
- D_tuse_rs, input, 2: cycles until D needs rs; 3 = never used.
- D_tuse_rt, input, 2: cycles until D needs rt; 3 = never used.
- D_is_md, input, 1: D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- E_A3, input, 5: destination register of the instruction in E; 0 = none.
- E_tnew, input, 2: cycles until E's result is forwardable.
- M_A3, input, 5: destination register of the instruction in M.
- M_tnew, input, 2: cycles until M's result is forwardable.
- E_md_start, input, 1: a mult/multu/div/divu is in E this cycle.
- E_md_div, input, 1: qualifies E_md_start; 1 = divide, 0 = multiply.
- stall, output, 1: combinational; freeze PC and F/D, clear D/E.
- pc_en, output, 1: equals ~stall.
- fd_en, output, 1: equals ~stall.
- de_clr, output, 1: equals stall.
- md_busy, output, 1: registered busy counter is nonzero.
- stall_cycles, output, 32: saturating count of stalled cycles.

## Operation
- Data hazard, rs: stall_rs = (D_rs != 0) & ((D_rs == E_A3 & D_tuse_rs < E_tnew) | (D_rs == M_A3 & D_tuse_rs < M_tnew)).
- Data hazard, rt: stall_rt is the same expression using D_rt and D_tuse_rt.
- MD hazard: stall_md = D_is_md & (md_busy | E_md_start).
- stall = stall_rs | stall_rt | stall_md.
- All comparisons are 2-bit unsigned.
- Register 0 never causes a stall, even when E_A3 or M_A3 is 0.
- Busy counter states:
  - IDLE: cnt = 0.
  - BUSY: cnt > 0.
- IDLE -> BUSY: E_md_start = 1 at a clock edge loads cnt with DIV_LAT if E_md_div = 1, otherwise MULT_LAT.
- In BUSY: cnt decrements by 1 per cycle; BUSY -> IDLE when cnt reaches 0.
- E_md_start while BUSY is ignored: no reload, cnt keeps decrementing. This case cannot arise legally because stall_md holds MD instructions in D.
- stall_cycles increments by 1 on every clock edge where stall = 1. It saturates at 0xFFFFFFFF and never wraps.

## Timing
- Reset (synchronous, clk edge with reset = 1): cnt = 0, md_busy = 0, stall_cycles = 0.
- After reset, stall is a pure function of inputs; with all inputs 0, stall = 0, pc_en = 1, fd_en = 1, de_clr = 0.
- Reset asserted mid-BUSY: cnt clears at that edge; md_busy = 0 in the following cycle.
- stall, pc_en, fd_en and de_clr are combinational with zero latency. They are sampled by the PC, F/D and D/E registers at the same edge.
- Multiply start: E_md_start sampled at edge t gives md_busy = 1 during cycles t+1 .. t+MULT_LAT.
- Divide start: E_md_start sampled at edge t gives md_busy = 1 during cycles t+1 .. t+DIV_LAT.
- md_busy falls after the last busy cycle. An MD instruction waiting in D issues in the first cycle with md_busy = 0.
- During the start cycle itself, stall_md is covered by the E_md_start term.
- stall_cycles updates one edge after the stalled cycle.

## Test plan
- Load-use: E_A3 = 8, E_tnew = 2, D_rs = 8, D_tuse_rs = 1 -> stall = 1, de_clr = 1, pc_en = 0. Changing to E_tnew = 1 -> stall = 0.
- Zero register: D_rs = 0, E_A3 = 0, E_tnew = 2, D_tuse_rs = 0 -> stall = 0.
- M-stage hazard: M_A3 = 5, M_tnew = 1, D_rt = 5, D_tuse_rt = 0 -> stall = 1. Changing D_tuse_rt to 3 -> stall = 0.
- Multiply followed by mflo:
  - Stimulus: pulse E_md_start = 1, E_md_div = 0 for one cycle, with D_is_md = 1 held throughout.
  - Required: stall = 1 for 6 consecutive cycles (start cycle plus 5 busy cycles); md_busy = 1 for exactly 5 cycles; stall_cycles = 6 afterwards.
- Divide interrupted by reset:
  - Stimulus: E_md_start = 1 with E_md_div = 1, then reset = 1 on the 4th busy cycle.
  - Required: md_busy = 0 in the next cycle; stall_cycles = 0.
  - Required: a new multiply start afterwards gives exactly 5 busy cycles.
- Saturation: force stall_cycles to 0xFFFFFFFE via a hierarchical deposit, then hold stall = 1 for 3 cycles -> counter reads 0xFFFFFFFF and stays there.
